// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encoding and time-of-day limits
//
// Purpose: mode_t for the mode/timing controller plus the field widths and
// limits used by the sec/min/hr counter datapath.
// Ports: none (package).

package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_ctrl_btn_cond.sv
// rtl/clock_ctrl_btn_cond.sv - push-button synchronizer, debounce, press detect, auto-repeat
//
// Purpose: conditions one raw asynchronous push-button into single-cycle
// press pulses, optionally followed by auto-repeat pulses while held.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-low
//   btn_raw  in   raw button level, asynchronous, active-high
//   rep_clr  in   cancels an active auto-repeat until the next fresh press
//   pulse    out  registered 1-cycle press / repeat pulse

module btn_cond
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 500000,
  parameter bit REPEAT_EN        = 1'b0,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic rep_clr,
  output logic pulse
);

  localparam int RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                               : REPEAT_RATE_CYC;
  localparam int DB_W = cnt_w(DEBOUNCE_CYC);
  localparam int RP_W = cnt_w(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYC - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            deb_q, deb_d;
  logic            deb_prev_q, deb_prev_d;
  logic            armed_q, armed_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            rep_act_q, rep_act_d;
  logic            rep_first_q, rep_first_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            pulse_q, pulse_d;
  logic            press;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;

    // Stability counter: runs only while the synced level disagrees with the
    // accepted level; the level is accepted once it has held long enough.
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    deb_prev_d = deb_q;

    // A button held through reset must be seen released before it can press.
    // The synchronizer resets to "held" so that case is not mistaken for a release.
    armed_d = armed_q | ~sync2_q;

    press   = deb_q & ~deb_prev_q & armed_q;
    pulse_d = press;

    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    if (REPEAT_EN) begin
      if (press) begin
        rep_act_d   = 1'b1;
        rep_first_d = 1'b1;
        rep_cnt_d   = '0;
      end else if (!deb_q || rep_clr || !rep_act_q) begin
        rep_act_d = 1'b0;
        rep_cnt_d = '0;
      end else if (rep_cnt_q == (rep_first_q ? DELAY_LAST : RATE_LAST)) begin
        pulse_d     = 1'b1;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_q       <= 1'b0;
      deb_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      db_cnt_q    <= '0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      armed_q     <= armed_d;
      db_cnt_q    <= db_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
      pulse_q     <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - mode and timing controller for the time-of-day counter
//
// Purpose: conditions the mode/adjust buttons, runs the HH:MM setting state
// machine, generates the 1 Hz prescaler and the display blink mask. All
// outputs are single-cycle enables or levels registered on clk.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-low
//   btn_mode  in   raw mode button, asynchronous, active-high
//   btn_adj   in   raw adjust button, asynchronous, active-high
//   run_tick  out  1-cycle pulse once per second, RUN only
//   inc_min   out  1-cycle increment-minute enable (SET_MIN)
//   inc_hr    out  1-cycle increment-hour enable (SET_HR)
//   clr_sec   out  1-cycle seconds clear on entry to RUN
//   mode      out  current mode_t
//   blink     out  display enable for the field being set; 1 in RUN

module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ           = 50000000,
  parameter int DEBOUNCE_CYC     = 500000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000,
  parameter int BLINK_CYC        = 12500000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn_mode,
  input  logic  btn_adj,
  output logic  run_tick,
  output logic  inc_min,
  output logic  inc_hr,
  output logic  clr_sec,
  output mode_t mode,
  output logic  blink
);

  localparam int PRE_W = cnt_w(CLK_HZ);
  localparam int BLK_W = cnt_w(BLINK_CYC);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_HZ - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYC - 1);

  logic             mode_press;
  logic             adj_pulse;

  mode_t            mode_q, mode_d;
  logic             run_tick_q, run_tick_d;
  logic             inc_min_q, inc_min_d;
  logic             inc_hr_q, inc_hr_d;
  logic             clr_sec_q, clr_sec_d;
  logic             blink_q, blink_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;

  btn_cond #(
    .DEBOUNCE_CYC    (DEBOUNCE_CYC),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
  ) u_mode_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_mode),
    .rep_clr(1'b0),
    .pulse  (mode_press)
  );

  // Every mode press changes mode, so it also cancels any adjust repeat.
  btn_cond #(
    .DEBOUNCE_CYC    (DEBOUNCE_CYC),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
  ) u_adj_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_adj),
    .rep_clr(mode_press),
    .pulse  (adj_pulse)
  );

  always_comb begin
    mode_d      = mode_q;
    run_tick_d  = 1'b0;
    inc_min_d   = 1'b0;
    inc_hr_d    = 1'b0;
    clr_sec_d   = 1'b0;
    pre_d       = '0;
    blink_cnt_d = '0;
    blink_d     = 1'b1;

    if (mode_press) begin
      // Mode change wins over any coincident adjust pulse; prescaler and
      // blink restart from their initial phase.
      unique case (mode_q)
        MODE_SET_HR:  mode_d = MODE_SET_MIN;
        MODE_SET_MIN: begin
          mode_d    = MODE_RUN;
          clr_sec_d = 1'b1;
        end
        default:      mode_d = MODE_SET_HR;
      endcase
    end else if (mode_q == MODE_RUN) begin
      if (pre_q == PRE_LAST) begin
        run_tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end else begin
      inc_hr_d  = adj_pulse & (mode_q == MODE_SET_HR);
      inc_min_d = adj_pulse & (mode_q == MODE_SET_MIN);
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q      <= MODE_SET_HR;
      run_tick_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_hr_q    <= 1'b0;
      clr_sec_q   <= 1'b0;
      blink_q     <= 1'b1;
      pre_q       <= '0;
      blink_cnt_q <= '0;
    end else begin
      mode_q      <= mode_d;
      run_tick_q  <= run_tick_d;
      inc_min_q   <= inc_min_d;
      inc_hr_q    <= inc_hr_d;
      clr_sec_q   <= clr_sec_d;
      blink_q     <= blink_d;
      pre_q       <= pre_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign run_tick = run_tick_q;
  assign inc_min  = inc_min_q;
  assign inc_hr   = inc_hr_q;
  assign clr_sec  = clr_sec_q;
  assign mode     = mode_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - directed self-checking bench for clock_ctrl

module tb_clock_ctrl;
  import clock_pkg::*;

  logic  clk;
  logic  rst;
  logic  btn_mode;
  logic  btn_adj;
  logic  run_tick;
  logic  inc_min;
  logic  inc_hr;
  logic  clr_sec;
  mode_t mode;
  logic  blink;

  int n_cmp;
  int n_bad;
  int cyc;
  int hr_q[$];
  int min_q[$];
  int tick_q[$];
  int clr_q[$];
  int t;
  int c;
  int m;
  int late;

  clock_ctrl #(
    .CLK_HZ          (10),
    .DEBOUNCE_CYC    (4),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_RATE_CYC (5),
    .BLINK_CYC       (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_mode(btn_mode),
    .btn_adj (btn_adj),
    .run_tick(run_tick),
    .inc_min (inc_min),
    .inc_hr  (inc_hr),
    .clr_sec (clr_sec),
    .mode    (mode),
    .blink   (blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of rising edges so far; pulses are logged by the edge that produced them.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inc_hr)   hr_q.push_back(cyc);
    if (inc_min)  min_q.push_back(cyc);
    if (run_tick) tick_q.push_back(cyc);
    if (clr_sec)  clr_q.push_back(cyc);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hr_q.delete();
    min_q.delete();
    tick_q.delete();
    clr_q.delete();
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    btn_mode = 1'b0;
    btn_adj  = 1'b0;

    // Reset state
    wait_cyc(3);
    check("rst_mode", mode, MODE_SET_HR);
    check("rst_blink", blink, 1);
    check("rst_inc_hr", inc_hr, 0);
    check("rst_inc_min", inc_min, 0);
    check("rst_run_tick", run_tick, 0);
    check("rst_clr_sec", clr_sec, 0);
    rst = 1'b1;
    wait_cyc(5);
    clear_logs();

    // 1: held adjust in SET_HR -> t+7, then repeat at t+27, t+32, t+37
    btn_adj = 1'b1;
    t = cyc + 1;
    wait_cyc(40);
    check("s1_hr_count", hr_q.size(), 4);
    check("s1_hr_first", at(hr_q, 0), t + 7);
    check("s1_hr_rep1", at(hr_q, 1), t + 27);
    check("s1_hr_rep2", at(hr_q, 2), t + 32);
    check("s1_hr_rep3", at(hr_q, 3), t + 37);
    check("s1_no_min", min_q.size(), 0);
    check("s1_mode", mode, MODE_SET_HR);
    btn_adj = 1'b0;
    wait_cyc(12);
    clear_logs();

    // 2: 3-cycle glitch rejected; bounce then steady high -> one pulse
    btn_adj = 1'b1;
    wait_cyc(3);
    btn_adj = 1'b0;
    wait_cyc(15);
    check("s2_glitch", hr_q.size(), 0);
    btn_adj = 1'b1; wait_cyc(1);
    btn_adj = 1'b0; wait_cyc(1);
    btn_adj = 1'b1; wait_cyc(1);
    btn_adj = 1'b0; wait_cyc(1);
    btn_adj = 1'b1;
    t = cyc + 1;
    wait_cyc(16);
    check("s2_bounce_count", hr_q.size(), 1);
    check("s2_bounce_time", at(hr_q, 0), t + 7);
    btn_adj = 1'b0;
    wait_cyc(12);
    clear_logs();

    // 3: SET_HR -> SET_MIN -> RUN; clr_sec at entry, ticks every 10
    btn_mode = 1'b1;
    t = cyc + 1;
    wait_cyc(7);
    check("s3_mode_before", mode, MODE_SET_HR);
    wait_cyc(1);
    check("s3_mode_setmin", mode, MODE_SET_MIN);
    check("s3_blink_entry", blink, 1);
    btn_mode = 1'b0;
    wait_cyc(7);
    check("s3_blink_hold", blink, 1);
    wait_cyc(1);
    check("s3_blink_toggle", blink, 0);
    wait_cyc(12);
    clear_logs();
    btn_mode = 1'b1;
    c = cyc + 8;
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(33);
    check("s3_mode_run", mode, MODE_RUN);
    check("s3_blink_run", blink, 1);
    check("s3_clr_count", clr_q.size(), 1);
    check("s3_clr_time", at(clr_q, 0), c);
    check("s3_tick_count", tick_q.size(), 3);
    check("s3_tick1", at(tick_q, 0), c + 10);
    check("s3_tick2", at(tick_q, 1), c + 20);
    check("s3_tick3", at(tick_q, 2), c + 30);
    check("s3_no_inc", hr_q.size() + min_q.size(), 0);
    clear_logs();

    // 4: adjust ignored in RUN; mode press back to SET_HR stops ticks
    btn_adj = 1'b1;
    wait_cyc(12);
    btn_adj = 1'b0;
    wait_cyc(12);
    check("s4_run_no_hr", hr_q.size(), 0);
    check("s4_run_no_min", min_q.size(), 0);
    check("s4_run_mode", mode, MODE_RUN);
    btn_mode = 1'b1;
    m = cyc + 8;
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(30);
    late = 0;
    foreach (tick_q[i]) if (tick_q[i] >= m) late++;
    check("s4_ticks_stopped", late, 0);
    check("s4_mode_sethr", mode, MODE_SET_HR);
    check("s4_no_clr", clr_q.size(), 0);
    clear_logs();

    // 5: simultaneous mode+adjust -> mode wins, repeat cancelled
    btn_mode = 1'b1;
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(12);
    check("s5_mode_setmin", mode, MODE_SET_MIN);
    clear_logs();
    btn_mode = 1'b1;
    btn_adj  = 1'b1;
    wait_cyc(40);
    check("s5_mode_run", mode, MODE_RUN);
    check("s5_no_min", min_q.size(), 0);
    check("s5_clr_once", clr_q.size(), 1);
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    wait_cyc(12);
    clear_logs();
    btn_mode = 1'b1;
    btn_adj  = 1'b1;
    wait_cyc(40);
    check("s5b_mode_sethr", mode, MODE_SET_HR);
    check("s5b_no_hr_repeat", hr_q.size(), 0);
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    wait_cyc(12);
    clear_logs();

    // 6: reset mid-repeat in SET_MIN
    btn_mode = 1'b1;
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(12);
    check("s6_mode_setmin", mode, MODE_SET_MIN);
    clear_logs();
    btn_adj = 1'b1;
    t = cyc + 1;
    wait_cyc(29);
    check("s6_min_count", min_q.size(), 2);
    check("s6_min_rep", at(min_q, 1), t + 27);
    rst = 1'b0;
    wait_cyc(1);
    check("s6_rst_mode", mode, MODE_SET_HR);
    check("s6_rst_blink", blink, 1);
    check("s6_rst_pulses", {28'd0, inc_hr, inc_min, run_tick, clr_sec}, 0);
    rst = 1'b1;
    clear_logs();
    wait_cyc(40);
    check("s6_held_no_hr", hr_q.size(), 0);
    check("s6_held_no_min", min_q.size(), 0);
    btn_adj = 1'b0;
    wait_cyc(12);
    clear_logs();
    btn_adj = 1'b1;
    t = cyc + 1;
    wait_cyc(12);
    check("s6_repress_count", hr_q.size(), 1);
    check("s6_repress_time", at(hr_q, 0), t + 7);
    btn_adj = 1'b0;
    wait_cyc(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Mode and timing controller for the time-of-day counter. It conditions the raw mode and adjust push-buttons, runs the HH:MM setting state machine, and generates the 1 Hz prescaler. It drives single-cycle enables into the sec/min/hr counter datapath and a blink mask for the display. The whole block is fully synchronous on clk, so the counter datapath no longer uses derived clocks.

Parameters:
CLK_HZ, 50000000, clk cycles per second; prescaler period
DEBOUNCE_CYC, 500000, consecutive stable cycles needed to accept a button level change
REPEAT_DELAY_CYC, 25000000, cycles from first adjust pulse to first auto-repeat pulse
REPEAT_RATE_CYC, 5000000, cycles between auto-repeat pulses
BLINK_CYC, 12500000, cycles per blink half-period

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
btn_mode  in  1  raw mode button, asynchronous, active-high
btn_adj  in  1  raw adjust button, asynchronous, active-high
run_tick  out  1  1-cycle pulse once per second, only in RUN
inc_min  out  1  1-cycle increment-minute enable (set mode)
inc_hr  out  1  1-cycle increment-hour enable (set mode)
clr_sec  out  1  1-cycle seconds clear on exit to RUN
mode  out  2  current mode_t
blink  out  1  display enable for the field being set; 1 in RUN

Behaviour:
- Interface: reset rst, synchronous, active-low; clock clk. All outputs are registered.
- Reset values: mode=MODE_SET_HR; run_tick=inc_min=inc_hr=clr_sec=0; blink=1; all counters 0; debounced levels 0.
- A reset asserted mid-operation overrides everything at the next edge, including pending presses and repeats.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Stability counter increments while the synced level differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYC-1 and the levels still differ, the debounced level flips at the next edge.
  - Press = rising edge of the debounced level.
- Fixed latency: a raw rise sampled at edge t produces its output pulse at edge t+2+DEBOUNCE_CYC+1.
- FSM, advanced on a mode press: MODE_SET_HR -> MODE_SET_MIN -> MODE_RUN -> MODE_SET_HR.
- Adjust press:
  - SET_HR: pulse inc_hr.
  - SET_MIN: pulse inc_min.
  - RUN: ignored.
- Auto-repeat, SET states only:
  - While the debounced adjust level stays high, pulse again REPEAT_DELAY_CYC cycles after the first pulse, then every REPEAT_RATE_CYC.
  - The repeat counter clears on release or on any mode change.
- Simultaneous mode and adjust press in the same cycle: mode wins, no inc pulse is issued, and repeat is cancelled until adjust is released and pressed again.
- SET_MIN -> RUN transition: clr_sec pulses in the cycle the mode changes and the prescaler is forced to 0.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in RUN; held at 0 in SET states.
  - run_tick pulses when the count is CLK_HZ-1, then wraps.
  - The first run_tick arrives exactly CLK_HZ cycles after clr_sec.
- Blink:
  - In SET states, blink toggles every BLINK_CYC cycles.
  - The blink counter resets and blink=1 on every mode change.
  - In RUN, blink=1 constantly.
- At most one of inc_min/inc_hr asserts per cycle. run_tick never asserts outside RUN.

Decomposition:
- Package clock_pkg:
  - mode_t: 2-bit enum {MODE_RUN, MODE_SET_HR, MODE_SET_MIN}.
  - Width constants SEC_W=6, MIN_W=6, HR_W=5.
  - Limits SEC_MAX=59, MIN_MAX=59, HR_MAX=23, shared with the counter datapath.
- Sub-module btn_cond: synchronizer, debounce, edge detect, optional auto-repeat via parameter REPEAT_EN. Instantiated twice, mode with REPEAT_EN=0 and adjust with REPEAT_EN=1.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=10, DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, BLINK_CYC=8.
1. Release reset; hold btn_adj high from edge t -> mode=MODE_SET_HR, blink=1; inc_hr pulses at t+7, t+27, t+32, t+37; no inc_min.
2. btn_adj glitch high for 3 cycles -> no pulses. Then a 4-cycle bounce followed by a steady high -> exactly one inc_hr.
3. Two mode presses from SET_HR -> mode goes SET_MIN then RUN; clr_sec pulses once at the RUN entry cycle c; run_tick pulses at c+10, c+20, c+30.
4. In RUN, press btn_adj -> no inc pulses and mode stays RUN. A mode press returns to SET_HR, run_tick stops, and the prescaler is held at 0.
5. Debounced mode and adjust rise in the same cycle in SET_MIN -> mode=MODE_RUN, no inc_min; holding adjust for 40 cycles yields no repeat.
6. Drive rst=0 for 1 cycle mid-repeat in SET_MIN -> the next edge gives mode=MODE_SET_HR, all pulses 0, blink=1; no inc pulse until adjust is released and pressed again.
